alu_cmd_ctrl: RTL and testbench
===============================

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the byte, operand and UART data width.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 2*DATA_WIDTH, the ALU result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the maximum cycles to wait for alu_valid after alu_en.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; all state updates on the rising edge of clk.
REQ-005 The block SHALL have these ports:
  clk  input  1  system clock
  rst  input  1  asynchronous active-low reset
  rx_data  input  DATA_WIDTH  received UART byte
  rx_valid  input  1  one-cycle strobe, rx_data valid
  alu_en  output  1  one-cycle ALU operation request
  alu_a  output  DATA_WIDTH  operand A to ALU
  alu_b  output  DATA_WIDTH  operand B to ALU
  alu_fun  output  4  ALU function code
  alu_out  input  OUT_WIDTH  ALU result
  alu_valid  input  1  ALU result valid
  tx_data  output  DATA_WIDTH  byte to UART transmitter
  tx_valid  output  1  tx_data valid, held until accepted
  tx_ready  input  1  transmitter accepts tx_data when high with tx_valid
  busy  output  1  high in every state except IDLE
  err  output  1  one-cycle pulse on ALU timeout

Function
REQ-006 The block SHALL be an FSM with states IDLE, GET_A, GET_B, GET_FUN, ALU_REQ, ALU_WAIT, TX_LO, TX_HI.
REQ-007 IDLE: on rx_valid with rx_data==8'hCC SHALL go to GET_A; any other byte SHALL be discarded, FSM stays in IDLE.
REQ-008 GET_A, GET_B: on rx_valid SHALL latch rx_data into alu_a, then alu_b respectively and advance to the next state.
REQ-009 GET_FUN: on rx_valid SHALL latch rx_data[3:0] into alu_fun, discard rx_data[7:4], go to ALU_REQ.
REQ-010 ALU_REQ: SHALL assert alu_en for exactly one cycle, clear the timeout counter, go to ALU_WAIT.
REQ-011 alu_a, alu_b, alu_fun SHALL remain stable from ALU_REQ until the FSM returns to IDLE.
REQ-012 ALU_WAIT: on alu_valid SHALL capture alu_out into an OUT_WIDTH result register and go to TX_LO.
REQ-013 ALU_WAIT: if alu_valid has not been seen after TIMEOUT cycles, SHALL load result with all-ones, pulse err one cycle, go to TX_LO.
REQ-014 alu_valid in any state other than ALU_WAIT SHALL be ignored.
REQ-015 TX_LO: SHALL drive tx_data=result[DATA_WIDTH-1:0] with tx_valid=1; on tx_valid&&tx_ready SHALL go to TX_HI.
REQ-016 TX_HI: SHALL drive tx_data=result[OUT_WIDTH-1:DATA_WIDTH] with tx_valid=1; on tx_valid&&tx_ready SHALL go to IDLE.
REQ-017 tx_valid SHALL be registered, never drop before acceptance, and deassert the cycle after the high byte is accepted.
REQ-018 tx_data SHALL not change while tx_valid is high and tx_ready is low.
REQ-019 rx_valid strobes in ALU_REQ, ALU_WAIT, TX_LO, TX_HI SHALL be dropped; no frame buffering.
REQ-020 Minimum latency: last frame byte to alu_en = 1 cycle; alu_valid to tx_valid = 1 cycle.
REQ-021 A new frame SHALL be accepted starting the cycle after the FSM returns to IDLE.

Reset
REQ-022 On rst low, asynchronously: state=IDLE; alu_en, tx_valid, busy, err=0; alu_a, alu_b, tx_data=0; alu_fun=4'h0; result and timeout counter=0.
REQ-023 Reset asserted mid-frame or mid-transmission SHALL abort the operation with no further alu_en or tx_valid.

Verification
REQ-024 Frame CC,12,34,02, ALU returns 16'h03A8 two cycles after alu_en, tx_ready=1 -> one alu_en pulse, tx bytes A8 then 03, busy low afterward.
REQ-025 Bytes 55,CC,05,03,00 -> 55 discarded; ALU sees A=05, B=03, fun=0; returns 0008 -> tx 08, 00.
REQ-026 alu_valid never asserted -> err pulses once after 16 cycles in ALU_WAIT; tx bytes FF then FF.
REQ-027 tx_ready low 5 cycles in TX_LO -> tx_valid and tx_data=low byte held all 5 cycles; single transfer on tx_ready high.
REQ-028 rst pulsed low during ALU_WAIT -> all outputs return to reset values immediately; late alu_valid produces no tx_valid.
REQ-029 rx_valid strobes during TX_LO/TX_HI -> ignored; next frame decoded correctly only from IDLE.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// UART command frame (CC, A, B, FUN) to ALU request, result returned as two tx bytes, low byte first.
// Latency: last frame byte to alu_en 1 cycle; alu_valid to tx_valid 1 cycle.
// Backpressure: tx_valid/tx_data held until tx_ready; rx bytes outside framing states are dropped.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  alu_en,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_fun,
  input  logic [OUT_WIDTH-1:0]  alu_out,
  input  logic                  alu_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_BYTE = DATA_WIDTH'(8'hCC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_REQ, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state, state_nxt;
  logic [OUT_WIDTH-1:0]    result, result_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   tx_data_nxt;
  logic                    tx_fire;

  assign tx_fire = tx_valid && tx_ready;
  assign alu_en  = (state == ALU_REQ);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    result_nxt  = result;
    cnt_nxt     = cnt;
    timeout_hit = 1'b0;
    tx_data_nxt = '0;
    case (state)
      IDLE:     if (rx_valid && rx_data == CMD_BYTE) state_nxt = GET_A;
      GET_A:    if (rx_valid) state_nxt = GET_B;
      GET_B:    if (rx_valid) state_nxt = GET_FUN;
      GET_FUN:  if (rx_valid) state_nxt = ALU_REQ;
      ALU_REQ: begin
        cnt_nxt   = '0;
        state_nxt = ALU_WAIT;
      end
      ALU_WAIT: begin
        // a result arriving on the last allowed cycle still wins over the timeout
        if (alu_valid) begin
          result_nxt = alu_out;
          state_nxt  = TX_LO;
        end else if (cnt == CNT_LAST) begin
          result_nxt  = '1;
          timeout_hit = 1'b1;
          state_nxt   = TX_LO;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TX_LO:    if (tx_fire) state_nxt = TX_HI;
      TX_HI:    if (tx_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // tx_data is registered from the next state so it lines up with tx_valid
    if (state_nxt == TX_LO)
      tx_data_nxt = result_nxt[DATA_WIDTH-1:0];
    else if (state_nxt == TX_HI)
      tx_data_nxt = DATA_WIDTH'(result_nxt >> DATA_WIDTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      result   <= '0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_fun  <= 4'h0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      result   <= result_nxt;
      cnt      <= cnt_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= (state_nxt == TX_LO) || (state_nxt == TX_HI);
      err      <= timeout_hit;
      if (state == GET_A && rx_valid)   alu_a   <= rx_data;
      if (state == GET_B && rx_valid)   alu_b   <= rx_data;
      if (state == GET_FUN && rx_valid) alu_fun <= rx_data[3:0];
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: framing, ALU handshake, timeout, tx backpressure, reset abort.
module tb_alu_cmd_ctrl;
  localparam int DW = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          alu_en;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic [OW-1:0] alu_out;
  logic          alu_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0, en_cnt = 0, err_cnt = 0;
  int hs0, en0, er0, early, hold;

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_valid(alu_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // event counters sampled mid-cycle
  always @(negedge clk) begin
    if (tx_valid && tx_ready) hs_cnt++;
    if (alu_en) en_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rx_valid = 1'b0; rx_data = '0; alu_out = '0; alu_valid = 1'b0; tx_ready = 1'b1;
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_fun", alu_fun, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b1;
    tick();

    // basic frame, ALU answers two cycles after alu_en
    hs0 = hs_cnt; en0 = en_cnt;
    send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
    chk("t1_alu_en", alu_en, 1);
    chk("t1_alu_a", alu_a, 8'h12);
    chk("t1_alu_b", alu_b, 8'h34);
    chk("t1_alu_fun", alu_fun, 4'h2);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_alu_en_off", alu_en, 0);
    chk("t1_no_tx_yet", tx_valid, 0);
    tick();
    alu_out = 16'h03A8; alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("t1_lo_valid", tx_valid, 1);
    chk("t1_lo_data", tx_data, 8'hA8);
    chk("t1_err", err, 0);
    tick();
    chk("t1_hi_valid", tx_valid, 1);
    chk("t1_hi_data", tx_data, 8'h03);
    tick();
    chk("t1_done_valid", tx_valid, 0);
    chk("t1_done_busy", busy, 0);
    chk("t1_en_pulses", en_cnt - en0, 1);
    chk("t1_handshakes", hs_cnt - hs0, 2);

    // garbage byte before the frame
    send(8'h55);
    chk("t2_discard", busy, 0);
    send(8'hCC); send(8'h05); send(8'h03); send(8'h00);
    chk("t2_alu_en", alu_en, 1);
    chk("t2_alu_a", alu_a, 8'h05);
    chk("t2_alu_b", alu_b, 8'h03);
    chk("t2_alu_fun", alu_fun, 4'h0);
    tick();
    alu_out = 16'h0008; alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("t2_lo_data", tx_data, 8'h08);
    tick();
    chk("t2_hi_data", tx_data, 8'h00);
    chk("t2_hi_valid", tx_valid, 1);
    tick();
    chk("t2_done", tx_valid, 0);

    // ALU never answers; upper nibble of function byte dropped
    er0 = err_cnt;
    send(8'hCC); send(8'h11); send(8'h22); send(8'hA7);
    chk("t3_alu_fun", alu_fun, 4'h7);
    early = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (err !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b1) early++;
    end
    chk("t3_wait_quiet", early, 0);
    tick();
    chk("t3_err", err, 1);
    chk("t3_lo_valid", tx_valid, 1);
    chk("t3_lo_data", tx_data, 8'hFF);
    tick();
    chk("t3_err_off", err, 0);
    chk("t3_hi_data", tx_data, 8'hFF);
    tick();
    chk("t3_done", tx_valid, 0);
    chk("t3_err_pulses", err_cnt - er0, 1);

    // transmitter backpressure on both bytes
    hs0 = hs_cnt;
    tx_ready = 1'b0;
    send(8'hCC); send(8'h07); send(8'h09); send(8'h01);
    tick();
    alu_out = 16'h5A3C; alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("t4_lo_valid", tx_valid, 1);
    chk("t4_lo_data", tx_data, 8'h3C);
    hold = 0;
    repeat (4) begin
      tick();
      if (tx_valid !== 1'b1 || tx_data !== 8'h3C) hold++;
    end
    chk("t4_lo_hold", hold, 0);
    tx_ready = 1'b1;
    tick();
    chk("t4_hi_data", tx_data, 8'h5A);
    chk("t4_hi_valid", tx_valid, 1);
    tx_ready = 1'b0;
    tick();
    chk("t4_hi_hold", tx_data, 8'h5A);
    tx_ready = 1'b1;
    tick();
    chk("t4_done", tx_valid, 0);
    chk("t4_handshakes", hs_cnt - hs0, 2);

    // reset in ALU_WAIT, then a stale alu_valid
    hs0 = hs_cnt; en0 = en_cnt;
    send(8'hCC); send(8'h01); send(8'h02); send(8'h03);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_b", alu_b, 0);
    chk("t5_alu_fun", alu_fun, 0);
    chk("t5_alu_en", alu_en, 0);
    chk("t5_err", err, 0);
    tick();
    rst = 1'b1;
    alu_out = 16'h1234; alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();
    chk("t5_no_tx", tx_valid, 0);
    chk("t5_no_hs", hs_cnt - hs0, 0);
    chk("t5_idle", busy, 0);
    chk("t5_en_pulses", en_cnt - en0, 1);

    // rx strobes while transmitting are dropped
    tx_ready = 1'b0;
    send(8'hCC); send(8'h20); send(8'h30); send(8'h04);
    tick();
    alu_out = 16'h0102; alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    send(8'hCC); send(8'h11);
    chk("t6_lo_data", tx_data, 8'h02);
    chk("t6_lo_valid", tx_valid, 1);
    rx_data = 8'hCC; rx_valid = 1'b1; tx_ready = 1'b1;
    tick();
    chk("t6_hi_data", tx_data, 8'h01);
    tick();
    rx_valid = 1'b0;
    chk("t6_idle", busy, 0);
    chk("t6_tx_off", tx_valid, 0);
    send(8'hCC); send(8'h0A); send(8'h0B); send(8'h05);
    chk("t6_alu_en", alu_en, 1);
    chk("t6_alu_a", alu_a, 8'h0A);
    chk("t6_alu_b", alu_b, 8'h0B);
    chk("t6_alu_fun", alu_fun, 4'h5);
    tick();
    alu_out = 16'h0000; alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    tick();
    tick();
    chk("t6_done", tx_valid, 0);
    chk("t6_done_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
